pool_layer_mc: RTL and testbench

Multi-channel streaming pooling layer for the CIM inference pipeline. It replaces the fixed max-pool stage between convolution and fully-connected layers. It accepts one raster-ordered pixel per beat across all channels and computes non-overlapping `kernel_dim`×`kernel_dim` windows, in max or average mode selected at run time. Results are emitted one window per beat with backpressure from the next layer.

---
 rtl/pool_pkg.sv | 30 +++
 rtl/pool_window_acc.sv | 73 +++++++
 rtl/pool_layer_mc.sv | 175 +++++++++++++++++
 tb/tb_pool_layer_mc.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and size helpers for the multi-channel pooling layer.
// Optional average mode is compiled in with `define POOL_AVG_EN.
package pool_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } pool_state_t;

   // Accumulator width: room for a k*k sum only when averaging exists.
   function automatic int pool_acc_w(input int dw, input int k);
`ifdef POOL_AVG_EN
      return dw + 2 * $clog2(k);
`else
      return dw + 0 * k;
`endif
   endfunction

   // Number of complete windows per row/column; trailing pixels are dropped.
   function automatic int pool_out_width(input int w, input int k);
      return w / k;
   endfunction

endpackage

// File: rtl/pool_window_acc.sv
// Per-channel window accumulator bank with the averaging shift and output
// saturation. One entry per window column; the entry is reused for every
// window row. Average mode exists only with `define POOL_AVG_EN.
module pool_window_acc
   import pool_pkg::*;
#(
   parameter int out_width            = 12,
   parameter int kernel_dim           = 2,
   parameter int datatype_size        = 8,
   parameter int output_datatype_size = 8,
   parameter int acc_w                = 8,
   parameter int idx_w                = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_we,
   input  logic                            i_first,
   input  logic [idx_w-1:0]                i_idx,
   input  logic [datatype_size-1:0]        i_pix,
   input  pool_mode_t                      i_mode,
   output logic [output_datatype_size-1:0] o_result
);

   logic [acc_w-1:0] r_acc [out_width];
   logic [acc_w-1:0] w_entry;
   logic [acc_w-1:0] w_pix_ext;
   logic [acc_w-1:0] w_next;
   logic [acc_w-1:0] w_scaled;

   assign w_pix_ext = acc_w'(i_pix);
   assign w_entry   = r_acc[i_idx];

   // Updated entry value including the current pixel.
   always_comb begin
      w_next = w_pix_ext;
      if (!i_first) begin
`ifdef POOL_AVG_EN
         if (i_mode == POOL_AVG) w_next = w_entry + w_pix_ext;
         else                    w_next = (w_pix_ext > w_entry) ? w_pix_ext : w_entry;
`else
         w_next = (w_pix_ext > w_entry) ? w_pix_ext : w_entry;
`endif
      end
   end

`ifdef POOL_AVG_EN
   localparam int SHIFT = 2 * $clog2(kernel_dim);
   assign w_scaled = (i_mode == POOL_AVG) ? (w_next >> SHIFT) : w_next;
`else
   logic w_unused_mode;
   assign w_unused_mode = (i_mode == POOL_AVG);
   assign w_scaled      = w_next;
`endif

   generate
      if (acc_w > output_datatype_size) begin : g_sat
         assign o_result = (|w_scaled[acc_w-1:output_datatype_size]) ? '1
                           : w_scaled[output_datatype_size-1:0];
      end else begin : g_nosat
         assign o_result = output_datatype_size'(w_scaled);
      end
   endgenerate

   // Entry storage: load on a window's first pixel, fold in the rest.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < out_width; i++) r_acc[i] <= '0;
      end else if (i_we) begin
         r_acc[i_idx] <= w_next;
      end
   end

endmodule

// File: rtl/pool_layer_mc.sv
// Streaming multi-channel pooling layer: raster pixels in, one pooled window
// per beat out with backpressure. Average mode needs `define POOL_AVG_EN.
//
// state | meaning
// IDLE  | waiting for i_start, input stalled
// RUN   | accepting pixels, stalled only while a result is blocked downstream
// DRAIN | image fully received, waiting for the last window to leave
module pool_layer_mc
   import pool_pkg::*;
#(
   parameter int input_channels       = 6,
   parameter int img_width            = 24,
   parameter int kernel_dim           = 2,
   parameter int datatype_size        = 8,
   parameter int output_datatype_size = 8
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                i_start,
   input  logic                                                i_mode,
   input  logic                                                i_ibuf_we,
   input  logic [input_channels-1:0][datatype_size-1:0]        i_ibuf_wr_data,
   output logic                                                o_busy,
   input  logic                                                i_next_busy,
   output logic                                                o_func_valid,
   output logic [input_channels-1:0][output_datatype_size-1:0] o_func_data,
   output logic                                                o_done
);

   localparam int OUT_W = pool_out_width(img_width, kernel_dim);
   localparam int ACC_W = pool_acc_w(datatype_size, kernel_dim);
   localparam int CW    = (img_width > 1) ? $clog2(img_width) : 1;
   localparam int KW    = $clog2(kernel_dim);
   localparam int IW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [CW-1:0] LAST    = CW'(img_width - 1);
   localparam logic [CW-1:0] OUTW_C  = CW'(OUT_W);
   localparam logic [CW-1:0] OUTW_M1 = CW'(OUT_W - 1);
   localparam logic [KW-1:0] KLAST   = KW'(kernel_dim - 1);

   pool_state_t r_state, w_state_nxt;
   pool_mode_t  w_mode;

   logic [CW-1:0] r_row, r_col, r_rwin, r_cwin;
   logic [KW-1:0] r_rph, r_cph;
   logic          r_valid, r_last;
   logic [input_channels-1:0][output_datatype_size-1:0] r_data, w_result;

   logic w_accept, w_in_win, w_acc_we, w_first, w_win_done, w_win_last;
   logic w_img_end, w_xfer;

   assign o_busy     = (r_state == RUN) ? (r_valid && i_next_busy) : 1'b1;
   assign w_accept   = i_ibuf_we && !o_busy && !i_start;
   assign w_in_win   = (r_rwin < OUTW_C) && (r_cwin < OUTW_C);
   assign w_acc_we   = w_accept && w_in_win;
   assign w_first    = (r_rph == '0) && (r_cph == '0);
   assign w_win_done = w_acc_we && (r_rph == KLAST) && (r_cph == KLAST);
   assign w_win_last = (r_rwin == OUTW_M1) && (r_cwin == OUTW_M1);
   assign w_img_end  = w_accept && (r_row == LAST) && (r_col == LAST);
   assign w_xfer     = r_valid && !i_next_busy;

   assign o_func_valid = r_valid;
   assign o_func_data  = r_data;
   assign o_done       = w_xfer && r_last && !i_start;

`ifdef POOL_AVG_EN
   pool_mode_t r_mode;

   // Mode is captured once per image on i_start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_mode <= POOL_MAX;
      else if (i_start) r_mode <= i_mode ? POOL_AVG : POOL_MAX;
   end
   assign w_mode = r_mode;
`else
   logic w_unused_mode;
   assign w_unused_mode = i_mode;
   assign w_mode        = POOL_MAX;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state; DRAIN with nothing held means the last window already left
   // during RUN (trailing rows after the final window).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_start) w_state_nxt = RUN;
         RUN:     if (i_start) w_state_nxt = RUN;
                  else if (w_img_end) w_state_nxt = DRAIN;
         DRAIN:   if (i_start) w_state_nxt = RUN;
                  else if (!r_valid || (w_xfer && r_last)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Raster position, split into window index and phase inside the window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || i_start) begin
         r_row <= '0; r_col <= '0; r_rwin <= '0; r_cwin <= '0;
         r_rph <= '0; r_cph <= '0;
      end else if (w_accept) begin
         if (r_col == LAST) begin
            r_col  <= '0;
            r_cph  <= '0;
            r_cwin <= '0;
            if (r_row == LAST) begin
               r_row  <= '0;
               r_rph  <= '0;
               r_rwin <= '0;
            end else begin
               r_row <= r_row + 1'b1;
               if (r_rph == KLAST) begin
                  r_rph  <= '0;
                  r_rwin <= r_rwin + 1'b1;
               end else begin
                  r_rph <= r_rph + 1'b1;
               end
            end
         end else begin
            r_col <= r_col + 1'b1;
            if (r_cph == KLAST) begin
               r_cph  <= '0;
               r_cwin <= r_cwin + 1'b1;
            end else begin
               r_cph <= r_cph + 1'b1;
            end
         end
      end
   end

   // Single output register; a new result may load in the same cycle the
   // previous one transfers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
      end else if (i_start) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else if (w_win_done) begin
         r_valid <= 1'b1;
         r_last  <= w_win_last;
         r_data  <= w_result;
      end else if (w_xfer) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
   end

   for (genvar g = 0; g < input_channels; g++) begin : g_ch
      pool_window_acc #(
         .out_width           (OUT_W),
         .kernel_dim          (kernel_dim),
         .datatype_size       (datatype_size),
         .output_datatype_size(output_datatype_size),
         .acc_w               (ACC_W),
         .idx_w               (IW)
      ) u_acc (
         .clk     (clk),
         .rst     (rst),
         .i_we    (w_acc_we),
         .i_first (w_first),
         .i_idx   (r_cwin[IW-1:0]),
         .i_pix   (i_ibuf_wr_data[g]),
         .i_mode  (w_mode),
         .o_result(w_result[g])
      );
   end

endmodule

// File: tb/tb_pool_layer_mc.sv
// Bench for pool_layer_mc: a 4-wide and a 5-wide instance (2 channels, k=2),
// scoreboard of expected windows computed from whole images.
module tb_pool_layer_mc;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start [2];
   logic mode  [2];
   logic we    [2];
   logic nbusy [2];
   logic [1:0][7:0] wdata [2];
   logic busy  [2];
   logic valid [2];
   logic done  [2];
   logic [1:0][7:0] fdata [2];

   int total = 0;
   int bad   = 0;
   exp_t q0[$];
   exp_t q1[$];
   int exp_done [2];
   int done_cnt [2];
   bit rand_bp  [2];
   bit held     [2];
   logic [15:0] held_data [2];
   int px [2][25];
   int dir_pat [16] = '{1, 5, 2, 3, 4, 0, 7, 6, 9, 8, 2, 2, 1, 0, 3, 4};

   always #5 clk = ~clk;

   pool_layer_mc #(.input_channels(2), .img_width(4), .kernel_dim(2),
                   .datatype_size(8), .output_datatype_size(8)) u_dut4 (
      .clk(clk), .rst(rst), .i_start(start[0]), .i_mode(mode[0]),
      .i_ibuf_we(we[0]), .i_ibuf_wr_data(wdata[0]), .o_busy(busy[0]),
      .i_next_busy(nbusy[0]), .o_func_valid(valid[0]),
      .o_func_data(fdata[0]), .o_done(done[0]));

   pool_layer_mc #(.input_channels(2), .img_width(5), .kernel_dim(2),
                   .datatype_size(8), .output_datatype_size(8)) u_dut5 (
      .clk(clk), .rst(rst), .i_start(start[1]), .i_mode(mode[1]),
      .i_ibuf_we(we[1]), .i_ibuf_wr_data(wdata[1]), .o_busy(busy[1]),
      .i_next_busy(nbusy[1]), .o_func_valid(valid[1]),
      .o_func_data(fdata[1]), .o_done(done[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   // Reference: pool each complete 2x2 window of the stored image.
   function automatic void push_image(input int d, input int w, input bit avg);
      int ow;
      bit eff;
      ow  = w / 2;
      eff = avg;
`ifndef POOL_AVG_EN
      eff = 1'b0;
`endif
      for (int wr = 0; wr < ow; wr++) begin
         for (int wc = 0; wc < ow; wc++) begin
            exp_t e;
            e.data = '0;
            for (int ch = 0; ch < 2; ch++) begin
               int mx, sum, res, v;
               mx = 0;
               sum = 0;
               for (int dr = 0; dr < 2; dr++) begin
                  for (int dc = 0; dc < 2; dc++) begin
                     v = px[ch][(2 * wr + dr) * w + 2 * wc + dc];
                     sum += v;
                     if (v > mx) mx = v;
                  end
               end
               res = eff ? (sum / 4) : mx;
               if (res > 255) res = 255;
               e.data[ch*8 +: 8] = res[7:0];
            end
            e.last = (wr == ow - 1) && (wc == ow - 1);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
      exp_done[d]++;
   endfunction

   task automatic fill_directed();
      for (int i = 0; i < 16; i++) begin
         px[0][i] = dir_pat[i];
         px[1][i] = dir_pat[i] + 10;
      end
   endtask

   task automatic fill_random(input int w);
      for (int i = 0; i < w * w; i++) begin
         px[0][i] = int'($urandom_range(0, 255));
         px[1][i] = int'($urandom_range(0, 255));
      end
   endtask

   // The start beat also offers a garbage pixel that must be ignored.
   task automatic pulse_start(input int d, input bit m);
      start[d] = 1'b1;
      mode[d]  = m;
      we[d]    = 1'b1;
      wdata[d] = 16'hFFFF;
      @(posedge clk); #1;
      start[d] = 1'b0;
      we[d]    = 1'b0;
   endtask

   task automatic drive_pix(input int d, input int i);
      int n;
      bit acc;
      n   = 0;
      acc = 1'b0;
      we[d]    = 1'b1;
      wdata[d] = {px[1][i][7:0], px[0][i][7:0]};
      do begin
         @(negedge clk);
         acc = !busy[d];
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 200);
      chk("pixel_accept", acc, 1);
      we[d] = 1'b0;
   endtask

   task automatic drive_image(input int d, input int w, input bit m, input bit lat);
      pulse_start(d, m);
      for (int i = 0; i < w * w; i++) begin
         int r, c;
         r = i / w;
         c = i % w;
         drive_pix(d, i);
         if (lat)
            chk("latency_valid", valid[d],
                ((r % 2 == 1) && (c % 2 == 1) && (r < (w / 2) * 2) && (c < (w / 2) * 2)));
      end
   endtask

   task automatic wait_drain(input int d);
      int n;
      n = 0;
      while (qsize(d) != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_pending", qsize(d), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", busy[d], 1);
      chk("done_count", done_cnt[d], exp_done[d]);
   endtask

   task automatic stop_bp(input int d);
      rand_bp[d] = 1'b0;
      @(negedge clk);
      nbusy[d] = 1'b0;
      @(posedge clk); #1;
   endtask

   // Monitor: pop and compare on every transfer; check hold behaviour.
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (valid[d] && nbusy[d]) begin
               chk("busy_while_held", busy[d], 1);
               if (held[d]) chk("data_stable", fdata[d], held_data[d]);
               held[d]      = 1'b1;
               held_data[d] = fdata[d];
            end else begin
               held[d] = 1'b0;
            end
            if (valid[d] && !nbusy[d]) begin
               if (qsize(d) == 0) begin
                  chk("spurious_output", valid[d], 0);
               end else begin
                  exp_t e;
                  e = (d == 0) ? q0.pop_front() : q1.pop_front();
                  chk("window_data", fdata[d], e.data);
                  chk("done_on_last", done[d], e.last);
               end
            end else begin
               chk("done_without_xfer", done[d], 0);
            end
            if (done[d]) done_cnt[d]++;
         end
      end
   end

   // Random backpressure, changed just after each active edge.
   initial begin
      forever begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++)
            if (rand_bp[d]) nbusy[d] = ($urandom_range(0, 2) == 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      bit m;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; mode[d] = 1'b0; we[d] = 1'b0; nbusy[d] = 1'b0;
         wdata[d] = '0; exp_done[d] = 0; done_cnt[d] = 0;
         rand_bp[d] = 1'b0; held[d] = 1'b0; held_data[d] = '0;
      end
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("reset_busy", busy[d], 1);
         chk("reset_valid", valid[d], 0);
         chk("reset_data", fdata[d], 0);
         chk("reset_done", done[d], 0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Directed max then average, no backpressure, latency checked.
      fill_directed();
      push_image(0, 4, 1'b0);
      drive_image(0, 4, 1'b0, 1'b1);
      wait_drain(0);
      push_image(0, 4, 1'b1);
      drive_image(0, 4, 1'b1, 1'b1);
      wait_drain(0);

      // Backpressure for 3 cycles after the first result.
      push_image(0, 4, 1'b0);
      pulse_start(0, 1'b0);
      for (int i = 0; i < 6; i++) drive_pix(0, i);
      chk("bp_first_valid", valid[0], 1);
      nbusy[0] = 1'b1;
      we[0]    = 1'b1;
      wdata[0] = {px[1][6][7:0], px[0][6][7:0]};
      repeat (3) begin
         @(negedge clk);
         chk("bp_valid", valid[0], 1);
         chk("bp_data", fdata[0], 16'h0F05);
         chk("bp_busy", busy[0], 1);
         @(posedge clk); #1;
      end
      nbusy[0] = 1'b0;
      we[0]    = 1'b0;
      for (int i = 6; i < 16; i++) drive_pix(0, i);
      wait_drain(0);

      // Odd width: trailing row/column dropped, single done.
      fill_random(5);
      m = 1'($urandom_range(0, 1));
      push_image(1, 5, m);
      rand_bp[1] = 1'b1;
      drive_image(1, 5, m, 1'b0);
      wait_drain(1);
      stop_bp(1);

      // Abort by i_start after 6 pixels with a result held.
      fill_random(4);
      nbusy[0] = 1'b1;
      pulse_start(0, 1'b0);
      for (int i = 0; i < 6; i++) drive_pix(0, i);
      chk("abort_setup_valid", valid[0], 1);
      fill_random(4);
      m = 1'($urandom_range(0, 1));
      push_image(0, 4, m);
      pulse_start(0, m);
      chk("abort_drop_valid", valid[0], 0);
      @(negedge clk) nbusy[0] = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) drive_pix(0, i);
      wait_drain(0);

      // Asynchronous reset mid-image with a result held.
      fill_random(4);
      nbusy[0] = 1'b1;
      pulse_start(0, 1'b0);
      for (int i = 0; i < 6; i++) drive_pix(0, i);
      chk("rst_setup_valid", valid[0], 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid", valid[0], 0);
      chk("rst_mid_data", fdata[0], 0);
      chk("rst_mid_busy", busy[0], 1);
      chk("rst_mid_done", done[0], 0);
      @(negedge clk);
      rst = 1'b0;
      nbusy[0] = 1'b0;
      held[0] = 1'b0;
      held[1] = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         we[0]    = 1'b1;
         wdata[0] = 16'($urandom);
         @(negedge clk);
         chk("post_rst_busy", busy[0], 1);
         @(posedge clk); #1;
         chk("post_rst_valid", valid[0], 0);
      end
      we[0] = 1'b0;
      fill_random(4);
      m = 1'($urandom_range(0, 1));
      push_image(0, 4, m);
      drive_image(0, 4, m, 1'b1);
      wait_drain(0);

      // Random images with random backpressure on both instances.
      for (int t = 0; t < 6; t++) begin
         fill_random(4);
         m = 1'($urandom_range(0, 1));
         push_image(0, 4, m);
         rand_bp[0] = 1'b1;
         drive_image(0, 4, m, 1'b0);
         wait_drain(0);
         stop_bp(0);
      end
      for (int t = 0; t < 2; t++) begin
         fill_random(5);
         m = 1'($urandom_range(0, 1));
         push_image(1, 5, m);
         rand_bp[1] = 1'b1;
         drive_image(1, 5, m, 1'b0);
         wait_drain(1);
         stop_bp(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
